// File: rtl/dm_pkg.sv
// Shared sizing and types for the data memory controller and its write buffer.
package dm_pkg;
  localparam int DM_AW    = 11;
  localparam int DM_DW    = 16;
  localparam int WB_DEPTH = 4;
  localparam int WB_PTR_W = 2;
  localparam int WB_CNT_W = WB_PTR_W + 1;

  // One posted write: target word address plus store data.
  typedef struct packed {
    logic [DM_AW-1:0] addr;
    logic [DM_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/dm_write_buffer.sv
// Four-entry posted-write FIFO with a youngest-match address lookup.
module dm_write_buffer
  import dm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DM_AW-1:0]    push_addr,
  input  logic [DM_DW-1:0]    push_data,
  input  logic [DM_AW-1:0]    lookup_addr,
  output logic                hit,
  output logic [DM_DW-1:0]    hit_data,
  output logic [DM_AW-1:0]    head_addr,
  output logic [DM_DW-1:0]    head_data,
  output logic [WB_CNT_W-1:0] count
);

  wb_entry_t              entries [WB_DEPTH];
  logic [WB_PTR_W-1:0]    rd_ptr_reg;
  logic [WB_PTR_W-1:0]    wr_ptr_reg;
  logic [WB_CNT_W-1:0]    count_reg;
  logic [WB_DEPTH-1:0]    match;
  logic [WB_PTR_W-1:0]    idx;

  // A slot matches when it is occupied (its age is below count) and its address agrees.
  genvar gi;
  generate
    for (gi = 0; gi < WB_DEPTH; gi++) begin : g_match
      logic [WB_PTR_W-1:0] age;
      assign age       = WB_PTR_W'(gi) - rd_ptr_reg;
      assign match[gi] = ({1'b0, age} < count_reg) && (entries[gi].addr == lookup_addr);
    end
  endgenerate

  // Walk slots oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = rd_ptr_reg;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr_reg + WB_PTR_W'(k);
      if (match[idx]) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

  // Entry storage carries no reset; validity comes only from pointers and count.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr_reg] <= '{addr: push_addr, data: push_data};
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign head_addr = entries[rd_ptr_reg].addr;
  assign head_data = entries[rd_ptr_reg].data;
  assign count     = count_reg;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with posted writes: array, read forwarding mux and drain control.
module data_mem_ctrl
  import dm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DM_AW-1:0] addr_to_dm,
  input  logic [DM_DW-1:0] data_to_dm,
  input  logic             RdRam,
  input  logic             WrRam,
  output logic [DM_DW-1:0] data_from_dm,
  output logic             wb_empty,
  output logic             wb_full,
  output logic             wb_overflow
);

  logic [DM_DW-1:0]    mem [2**DM_AW];
  logic                hit;
  logic [DM_DW-1:0]    hit_data;
  logic [DM_AW-1:0]    head_addr;
  logic [DM_DW-1:0]    head_data;
  logic [WB_CNT_W-1:0] count;
  logic                drain;
  logic                accept;
  logic                overflow_reg;

  // The single array port is taken by a read, so the buffer drains only on idle-read cycles.
  assign drain    = !RdRam && (count != '0);
  // A full buffer still takes a write when the head leaves on the same edge.
  assign accept   = WrRam && (!wb_full || drain);
  assign wb_empty = (count == '0);
  assign wb_full  = (count == WB_CNT_W'(WB_DEPTH));

  dm_write_buffer u_wb (
    .clk         (clk),
    .reset       (reset),
    .push        (accept),
    .pop         (drain),
    .push_addr   (addr_to_dm),
    .push_data   (data_to_dm),
    .lookup_addr (addr_to_dm),
    .hit         (hit),
    .hit_data    (hit_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count)
  );

  // Commit the buffer head into the array; array contents survive reset.
  always_ff @(posedge clk) begin
    if (drain) mem[head_addr] <= head_data;
  end

  // Sticky record of any write that had to be dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 overflow_reg <= 1'b0;
    else if (WrRam && !accept)  overflow_reg <= 1'b1;
  end

  // Pending writes shadow the array; lookup sees pre-push contents only.
  always_comb begin
    data_from_dm = '0;
    if (RdRam) data_from_dm = hit ? hit_data : mem[addr_to_dm];
  end

  assign wb_overflow = overflow_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl against a queue/array model.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] addr_to_dm = '0;
  logic [15:0] data_to_dm = '0;
  logic        RdRam = 1'b0;
  logic        WrRam = 1'b0;
  logic [15:0] data_from_dm;
  logic        wb_empty;
  logic        wb_full;
  logic        wb_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         m_q[$];
  logic [15:0] m_mem [2048];
  logic        m_ovf = 1'b0;

  data_mem_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .addr_to_dm   (addr_to_dm),
    .data_to_dm   (data_to_dm),
    .RdRam        (RdRam),
    .WrRam        (WrRam),
    .data_from_dm (data_from_dm),
    .wb_empty     (wb_empty),
    .wb_full      (wb_full),
    .wb_overflow  (wb_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read: newest pending write to the address, else array, zero when not reading.
  function automatic logic [15:0] model_read(input logic rd, input logic [10:0] a);
    logic [15:0] v;
    if (!rd) return 16'h0000;
    v = m_mem[a];
    foreach (m_q[i]) if (m_q[i].addr == a) v = m_q[i].data;
    return v;
  endfunction

  task automatic check_flags(input string tag);
    check_val({tag, "_empty"}, {31'b0, wb_empty}, {31'b0, m_q.size() == 0});
    check_val({tag, "_full"},  {31'b0, wb_full},  {31'b0, m_q.size() == 4});
    check_val({tag, "_ovf"},   {31'b0, wb_overflow}, {31'b0, m_ovf});
  endtask

  // One bus cycle: drive, check the combinational read, clock, update model, check flags.
  task automatic do_cycle(input string tag, input logic rd, input logic wr,
                          input logic [10:0] a, input logic [15:0] d);
    bit drained;
    int sz;
    @(negedge clk);
    RdRam = rd; WrRam = wr; addr_to_dm = a; data_to_dm = d;
    #1;
    check_val({tag, "_rd"}, {16'b0, data_from_dm}, {16'b0, model_read(rd, a)});
    @(posedge clk);
    sz = m_q.size();
    drained = !rd && sz > 0;
    if (drained) begin
      m_mem[m_q[0].addr] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (wr) begin
      if (sz < 4 || drained) m_q.push_back('{addr: a, data: d});
      else m_ovf = 1'b1;
    end
    #1;
    check_flags(tag);
    $display("cyc %s rd=%0d wr=%0d addr=%h din=%h dout=%h pend=%0d", tag, rd, wr, a, d,
             data_from_dm, m_q.size());
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 8; i++) do_cycle(tag, 1'b0, 1'b0, 11'h0, 16'h0);
  endtask

  // Assert reset between edges, check immediate effect, release between edges.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    RdRam = 1'b0; WrRam = 1'b0;
    #2 reset = 1'b0;
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    check_flags(tag);
    check_val({tag, "_rd"}, {16'b0, data_from_dm}, 32'h0);
    $display("reset %s empty=%0d full=%0d ovf=%0d", tag, wb_empty, wb_full, wb_overflow);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 16'h0000;
    #3;
    check_flags("por");
    #10 reset = 1'b1;

    // Give every array word a known value by streaming zeros through the buffer.
    for (int a = 0; a < 2048; a++) begin
      @(negedge clk);
      RdRam = 1'b0; WrRam = 1'b1; addr_to_dm = 11'(a); data_to_dm = 16'h0;
      @(posedge clk);
      if (m_q.size() > 0) void'(m_q.pop_front());
      m_q.push_back('{addr: 11'(a), data: 16'h0});
    end
    drain_all("init");

    // Posted write forwarded on the next cycle.
    do_cycle("w05", 1'b0, 1'b1, 11'h005, 16'hBEEF);
    do_cycle("r05", 1'b1, 1'b0, 11'h005, 16'h0);
    check_val("r05_val", {16'b0, data_from_dm}, 32'h0000BEEF);
    drain_all("d1");

    // Fill with reads held, then overflow.
    for (int i = 0; i < 4; i++)
      do_cycle("fill", 1'b1, 1'b1, 11'h010 + 11'(i), 16'h1111 * 16'(i + 1));
    do_cycle("ovf", 1'b1, 1'b1, 11'h014, 16'h5555);
    check_val("ovf_set", {31'b0, wb_overflow}, 32'h1);
    drain_all("d2");
    do_cycle("r12", 1'b1, 1'b0, 11'h012, 16'h0);
    do_cycle("r14", 1'b1, 1'b0, 11'h014, 16'h0);
    pulse_reset("rst1");

    // Youngest of two pending writes wins.
    do_cycle("w20a", 1'b1, 1'b1, 11'h020, 16'hAAAA);
    do_cycle("w20b", 1'b1, 1'b1, 11'h020, 16'h5555);
    do_cycle("r20", 1'b1, 1'b0, 11'h020, 16'h0);
    check_val("r20_val", {16'b0, data_from_dm}, 32'h00005555);
    drain_all("d3");

    // Same-cycle read and write return the old value, new value next cycle.
    do_cycle("rw30", 1'b1, 1'b1, 11'h030, 16'h1234);
    do_cycle("r30", 1'b1, 1'b0, 11'h030, 16'h0);
    check_val("r30_val", {16'b0, data_from_dm}, 32'h00001234);
    drain_all("d4");

    // Full buffer with a drain on the same edge accepts the write.
    for (int i = 0; i < 4; i++)
      do_cycle("fill2", 1'b1, 1'b1, 11'h050 + 11'(i), 16'hC000 + 16'(i));
    do_cycle("fulldr", 1'b0, 1'b1, 11'h054, 16'hC004);
    check_val("fulldr_full", {31'b0, wb_full}, 32'h1);
    check_val("fulldr_ovf", {31'b0, wb_overflow}, 32'h0);
    drain_all("d5");
    for (int i = 0; i < 5; i++) do_cycle("rb5x", 1'b1, 1'b0, 11'h050 + 11'(i), 16'h0);

    // Random traffic on a small address window so lookups hit often.
    for (int i = 0; i < 400; i++)
      do_cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               11'h060 + 11'($urandom_range(0, 7)), 16'($urandom));
    drain_all("d6");
    for (int i = 0; i < 8; i++) do_cycle("rbrnd", 1'b1, 1'b0, 11'h060 + 11'(i), 16'h0);

    // Reset with pending entries discards them; array keeps earlier values.
    pulse_reset("rst2");
    for (int i = 0; i < 3; i++) do_cycle("pre", 1'b0, 1'b1, 11'h040 + 11'(i), 16'h7770 + 16'(i));
    drain_all("d7");
    for (int i = 0; i < 3; i++) do_cycle("pend", 1'b1, 1'b1, 11'h040 + 11'(i), 16'h9990 + 16'(i));
    pulse_reset("rst3");
    for (int i = 0; i < 3; i++) do_cycle("rbrst", 1'b1, 1'b0, 11'h040 + 11'(i), 16'h0);
    check_val("rbrst_val", {16'b0, data_from_dm}, 32'h00007772);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr_to_dm  input  11  data-memory word address from cpu.
REQ-005 data_to_dm  input  16  store data from cpu.
REQ-006 RdRam  input  1  read request, same cycle as address.
REQ-007 WrRam  input  1  write request, same cycle as address and data.
REQ-008 data_from_dm  output  16  read data to cpu (combinational).
REQ-009 wb_empty  output  1  write buffer holds 0 entries.
REQ-010 wb_full  output  1  write buffer holds 4 entries.
REQ-011 wb_overflow  output  1  sticky flag: a write was dropped.

Function
REQ-012 Storage SHALL be a 2048 x 16 array with asynchronous read and one synchronous write port.
REQ-013 Writes SHALL be posted into a 4-entry FIFO write buffer of {addr[10:0], data[15:0]}; 2-bit read/write pointers wrap 3->0; a 3-bit count runs 0..4.
REQ-014 Push: on an edge with WrRam=1, the entry SHALL be appended unless the write is dropped (REQ-018).
REQ-015 Drain: on an edge with RdRam=0 and count>0, the head entry SHALL be written into the array and popped; with RdRam=1 no drain occurs (port busy with the read).
REQ-016 Read: with RdRam=1, data_from_dm SHALL return the youngest buffer entry whose addr matches addr_to_dm, else array[addr_to_dm]; with RdRam=0, data_from_dm SHALL be 16'h0000.
REQ-017 Forwarding SHALL use buffer contents before the current cycle's push, so RdRam=1 and WrRam=1 to the same address in one cycle return the old value.
REQ-018 Full plus WrRam: if a drain occurs the same edge (RdRam=0), the push SHALL be accepted and count stays 4; if RdRam=1, the write SHALL be dropped and wb_overflow set.
REQ-019 Simultaneous push and drain with count 1..3 SHALL leave count unchanged.
REQ-020 wb_overflow SHALL stay set until reset.
REQ-021 wb_empty and wb_full SHALL be decoded from the registered count.
REQ-022 Latency: a posted write SHALL be readable by forwarding from the next cycle; it reaches the array at the first later edge with RdRam=0 once it is at the head.

Reset
REQ-023 Asserting reset SHALL immediately clear pointers, count and wb_overflow, giving wb_empty=1, wb_full=0 and wb_overflow=0, with data_from_dm following REQ-016.
REQ-024 Reset mid-operation SHALL discard all undrained entries; array contents SHALL NOT be reset.
REQ-025 Reset deassertion SHALL take effect at the next rising edge without glitching state.

Structure
REQ-026 A shared package dm_pkg SHALL hold DM_AW=11, DM_DW=16, WB_DEPTH=4 and WB_PTR_W=2.
REQ-027 The FIFO with its address-match lookup SHALL be a sub-module dm_write_buffer; data_mem_ctrl holds the array, read mux and drain control.

Verification
REQ-028 After reset, WrRam addr=0x005 data=0xBEEF, then RdRam addr=0x005 next cycle -> data_from_dm=0xBEEF, wb_empty=0.
REQ-029 Four writes (0x010..0x013 = 0x1111..0x4444) with RdRam held 1 -> wb_full=1; a fifth write -> wb_overflow=1, count stays 4.
REQ-030 Two writes to 0x020 (0xAAAA then 0x5555), then read with RdRam=1 -> 0x5555 (youngest wins).
REQ-031 Same-cycle RdRam=1, WrRam=1 at 0x030 (array 0x0000, write 0x1234) -> 0x0000 that cycle, 0x1234 next cycle.
REQ-032 Full buffer, RdRam=0, WrRam=1 -> write accepted, head drained to array, wb_full stays 1, wb_overflow=0.
REQ-033 Assert reset with 3 pending entries -> wb_empty=1 immediately; later reads of those addresses return prior array values.
